// File: rtl/arb_pkg.sv
// Shared types and sizes for the 12-way round-robin arbiter.
// Imported by the picker and the arbiter top.
package arb_pkg;
   localparam int ARB_N  = 12;
   localparam int PTR_W  = 4;
   localparam int BEAT_W = 8;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;
endpackage

// File: rtl/rr_pick12.sv
// Round-robin picker: first active request after ptr, wrapping 11 -> 0.
// The pointer itself is searched last, so a lone requester can win again.
module rr_pick12
   import arb_pkg::*;
(
   input  logic [ARB_N-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [ARB_N-1:0] win,
   output logic [PTR_W-1:0] win_idx,
   output logic             any
);

   // scan ptr+1 .. ptr+12 modulo 12, keep the first hit
   always_comb begin
      logic [4:0] idx;
      win     = '0;
      win_idx = ptr;
      any     = 1'b0;
      idx     = '0;
      for (int k = 1; k <= ARB_N; k++) begin
         idx = 5'(ptr) + 5'(k);
         if (idx >= 5'(ARB_N)) idx = idx - 5'(ARB_N);
         if (!any && req[idx[3:0]]) begin
            any              = 1'b1;
            win_idx          = idx[3:0];
            win[idx[3:0]]    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arbiter12_rr.sv
// Registered round-robin packet arbiter for 12 requesters.
// Grant is held from first beat until last (or beat limit) is accepted.
module arbiter12_rr
   import arb_pkg::*;
#(
   parameter int MAXLEN = 0
) (
   input  logic             clk,
   input  logic             nreset,
   input  logic [ARB_N-1:0] req,
   input  logic [ARB_N-1:0] last,
   input  logic             out_ready,
   output logic [ARB_N-1:0] grant,
   output logic             out_valid,
   output logic             out_last,
   output logic [ARB_N-1:0] req_ready,
   output logic             busy
);

   arb_state_t        state_q, state_d;
   logic [ARB_N-1:0]  grant_q, grant_d;
   logic [PTR_W-1:0]  ptr_q, ptr_d;
   logic [BEAT_W-1:0] beats_q, beats_d;

   logic [ARB_N-1:0]  pick_win;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_any;
   logic              accept;
   logic              at_limit;
   logic              rel;

   rr_pick12 u_pick (
      .req     (req),
      .ptr     (ptr_q),
      .win     (pick_win),
      .win_idx (pick_idx),
      .any     (pick_any)
   );

   assign grant     = grant_q;
   assign out_valid = |(grant_q & req);
   assign out_last  = |(grant_q & req & last);
   assign req_ready = grant_q & {ARB_N{out_ready}};
   assign busy      = (state_q == BUSY);

   assign accept   = out_valid & out_ready;
   assign at_limit = (MAXLEN != 0) &&
                     (({1'b0, beats_q} + 9'd1) == 9'(MAXLEN));
   assign rel      = accept & (out_last | at_limit);

   // state, pointer, grant and beat counter registers
   always_ff @(posedge clk) begin
      if (!nreset) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= PTR_W'(ARB_N - 1);
         beats_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         beats_q <= beats_d;
      end
   end

   // next-state: arbitrate in IDLE or on release, count beats in BUSY
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      beats_d = beats_q;
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = BUSY;
               grant_d = pick_win;
               ptr_d   = pick_idx;
               beats_d = '0;
            end
         end
         BUSY: begin
            if (accept && beats_q != '1) beats_d = beats_q + 1'b1;
            if (rel) begin
               beats_d = '0;
               if (pick_any) begin
                  grant_d = pick_win;
                  ptr_d   = pick_idx;
               end else begin
                  grant_d = '0;
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase
   end

endmodule

// File: doc/arbiter12_rr.md
# arbiter12_rr

Registered round-robin arbiter for 12 requesters. Produces the one-hot select vector that drives the `sel11..sel0` inputs of the downstream 12-way one-hot AND-OR mux, and returns per-requester ready. A grant is held for a whole packet: from first beat until the beat flagged `last` is accepted. An optional beat limit forces rotation for fairness.

## Interface
- `MAXLEN`, default 0: maximum beats per grant; 0 means unlimited. Legal range 0..255.
- `clk` input, 1: the only clock.
- `nreset` input, 1: synchronous, active-low reset.
- `req` input, 12: per-requester valid; bit i belongs to requester i.
- `last` input, 12: per-requester end-of-packet flag; only meaningful while the matching `req` bit is high.
- `out_ready` input, 1: downstream accepts the current beat.
- `grant` output, 12: registered one-hot (or zero) grant; wires directly to the mux `sel11..sel0`.
- `out_valid` output, 1: `|(grant & req)`, combinational.
- `out_last` output, 1: `|(grant & req & last)`.
- `req_ready` output, 12: `grant & {12{out_ready}}`, combinational.
- `busy` output, 1: high while state is BUSY.

## Operation
- States: IDLE (`grant` = 0) and BUSY (`grant` one-hot).
- Pointer `ptr[3:0]` holds the last winner. Search order is `ptr+1, ptr+2, …` wrapping 11→0. Index 12+ never occurs.
- IDLE:
  - If `|req`, register the winner into `grant`, set `ptr` = winner and `beats` = 0, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - A beat is accepted when `out_valid & out_ready`. Each accepted beat increments `beats` (8-bit, saturating).
- Release occurs when the accepted beat has `out_last` = 1, or when `MAXLEN != 0` and the accepted beat is beat number `MAXLEN`.
- On release, pick the next winner in the same cycle, searching after the current `ptr`:
  - If found: load the new grant, set `ptr` = new winner, reset `beats` to 0, and stay BUSY. This gives zero-bubble back-to-back packets.
  - If no other requester is active but the current one still requests, it wins again.
  - If no request at all: go to IDLE.
- If the granted requester drops `req` mid-packet, `grant` is held. `out_valid` is 0 and no beat is counted. The requester is never pre-empted without a release event.
- `req` bits of non-granted requesters never affect `grant` while BUSY.
- `grant` is at most one-hot in every cycle.

## Timing
- Reset values (first edge with `nreset`=0):
  - `grant` = 0, state = IDLE, `ptr` = 11 so requester 0 has first priority, `beats` = 0.
  - Therefore `out_valid` = 0, `out_last` = 0, `req_ready` = 0, `busy` = 0.
- Reset mid-packet discards the grant on that edge. There is no drain.
- Grant latency: `req` high in IDLE at cycle n gives `grant` and `out_valid` at cycle n+1.
- Release at edge n: the new grant is visible at n+1.
- Throughput: 1 beat/cycle while `out_ready`=1. No idle cycle between packets while requests are pending.
- `req_ready`, `out_valid` and `out_last` are combinational from registered `grant` and inputs. There is no path from `out_ready` to `grant` within the same cycle.

## Structure
- Shared package `arb_pkg`:
  - `ARB_N = 12`
  - pointer width 4
  - beat-counter width 8
  - state enum {IDLE, BUSY}
- Sub-module `rr_pick12`: purely combinational. Inputs are `req[11:0]` and `ptr[3:0]`. Outputs are a one-hot `win[11:0]`, `win_idx[3:0]` and `any`.
- `arbiter12_rr` contains the FSM, the `ptr`/`grant`/`beats` registers and the output assigns.

## Test plan
- After reset, `req`=0x001 with `out_ready`=1 and `last`=0x001: `grant`=0x001 one cycle later, one beat accepted, then return to IDLE (`busy`=0).
- `req`=0xFFF held, `last`=0xFFF, `out_ready`=1: grant sequence 0x001, 0x002, …, 0x800, 0x001 on consecutive cycles with no bubble.
- Requester 5 sends a 4-beat packet (`last` on beat 4) while requester 2 also requests; `out_ready` low in cycles 2–3: `grant`=0x020 held for 6 cycles, then 0x004.
- `MAXLEN`=3, requester 7 sends 10 beats without `last`, requester 8 also requests: `grant` moves to 0x100 after the 3rd accepted beat.
- Granted requester 3 drops `req` for 2 cycles mid-packet: `grant` stays 0x008, `out_valid`=0 and `req_ready[3]`=`out_ready`; the packet resumes and completes.
- `nreset` asserted mid-packet with `grant`=0x400: next cycle `grant`=0 and `busy`=0; after release, `req`=0xC01 wins requester 0 first.
